// File: rtl/instr_issue_pkg.sv
// Shared definitions for the instruction issue block and its controller FSM:
// state encodings, opcode constants and instruction field helpers.
package instr_issue_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_ACK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_HALT  = 3'd6
    } issue_state_e;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_HALT = 3'b111;

    function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[15:13];
    endfunction

    function automatic logic [1:0] op_of(input logic [INSTR_W-1:0] word);
        return word[12:11];
    endfunction

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return (opcode_of(word) == OPC_HALT);
    endfunction

endpackage

// File: rtl/instr_issue_pc_counter.sv
// Program counter with clear-to-zero and modulo-256 increment.
// Clear takes priority over increment.
module pc_counter
    import instr_issue_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clr,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Next program counter value
    always_comb begin
        pc_d = pc_q;
        if (clr) begin
            pc_d = {PC_W{1'b0}};
        end else if (inc) begin
            pc_d = pc_q + PC_W'(1);
        end else begin
            pc_d = pc_q;
        end
    end

    // Program counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= {PC_W{1'b0}};
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_issue.sv
// Instruction fetch/issue sequencer: fetches a word at pc, latches it, and
// hands it to the controller FSM through the s / w handshake.
module instr_issue
    import instr_issue_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               w,
    output logic [PC_W-1:0]    mem_addr,
    output logic               mem_rd,
    output logic               s,
    output logic [INSTR_W-1:0] instr,
    output logic [2:0]         opcode,
    output logic [1:0]         op,
    output logic [PC_W-1:0]    pc,
    output logic               halted
);

    issue_state_e       state_q;
    issue_state_e       state_d;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] instr_d;
    logic               mem_rd_q;
    logic               mem_rd_d;
    logic               halted_q;
    logic               halted_d;
    logic               pc_clr_s;
    logic               pc_inc_s;
    logic               s_s;

    pc_counter u_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (pc_clr_s),
        .inc     (pc_inc_s),
        .pc      (pc)
    );

    // Next-state, instruction capture and pc control
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc_clr_s = 1'b0;
        pc_inc_s = 1'b0;
        s_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_FETCH;
                    pc_clr_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                instr_d  = mem_rdata;
                pc_inc_s = 1'b1;
                if (is_halt(mem_rdata)) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w) begin
                    s_s     = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            // A controller still showing ready has not yet taken the instruction
            ST_ACK: begin
                if (!w) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_DONE: begin
                if (w) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_d  = ST_FETCH;
                    pc_clr_s = 1'b1;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        mem_rd_d = (state_d == ST_FETCH);
        halted_d = (state_d == ST_HALT);
    end

    // State, instruction register and registered strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            instr_q  <= 16'h0000;
            mem_rd_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            mem_rd_q <= mem_rd_d;
            halted_q <= halted_d;
        end
    end

    // The word is already visible during LOAD so the decoded fields lead ISSUE by a cycle.
    assign instr    = (state_q == ST_LOAD) ? mem_rdata : instr_q;
    assign opcode   = opcode_of(instr);
    assign op       = op_of(instr);
    assign s        = s_s;
    assign mem_rd   = mem_rd_q;
    assign halted   = halted_q;
    assign mem_addr = pc;

endmodule

// File: tb/tb_instr_issue.sv
// Self-checking bench for instr_issue: directed vector table, hand-written
// reset/wrap sequences and a randomized run against a transaction-level model.
module tb_instr_issue;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        w;
    logic [15:0] mem_rdata;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic        s;
    logic [15:0] instr;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [7:0]  pc;
    logic        halted;

    logic [15:0] mem [256];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        st;
        logic        wv;
        logic        e_rd;
        logic        e_s;
        logic        e_halt;
        logic [7:0]  e_pc;
        logic [15:0] e_instr;
    } vec_t;

    vec_t vt[$];

    // model / sequence state
    logic [7:0]  exp_addr;
    logic [7:0]  pend_addr;
    logic [15:0] pend_word;
    logic [15:0] ei;
    logic        pend_valid;
    logic        pend_halt;
    logic        pend_issued;
    logic        w_low;
    logic        st;
    logic        wv;
    logic        wnext;
    logic        seen;
    int          halt_cnt;
    int          phase;

    instr_issue dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .mem_rdata (mem_rdata),
        .w         (w),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .s         (s),
        .instr     (instr),
        .opcode    (opcode),
        .op        (op),
        .pc        (pc),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous instruction memory: data valid the cycle after mem_rd
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic stv, input logic wval);
        @(negedge clk);
        start = stv;
        w     = wval;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        w       = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic a, input logic b, input logic c, input logic d,
                                input logic e, input logic [7:0] f, input logic [15:0] g);
        vec_t v;
        v.st = a; v.wv = b; v.e_rd = c; v.e_s = d; v.e_halt = e; v.e_pc = f; v.e_instr = g;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        start   = 1'b0;
        w       = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'hD0A5;
        mem[1] = 16'hA123;
        mem[2] = 16'hE000;

        //        st    w     rd    s     halt  pc     instr
        vt.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0000)); // IDLE, start
        vt.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 16'h0000)); // FETCH @0
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'hD0A5)); // LOAD
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 16'hD0A5)); // ISSUE s
        for (int k = 0; k < 4; k++)
            vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 16'hD0A5)); // ACK, w held
        vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 16'hD0A5)); // ACK -> DONE
        vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 16'hD0A5)); // DONE
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 16'hD0A5)); // DONE -> FETCH
        vt.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 16'hD0A5)); // FETCH @1
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 16'hA123)); // LOAD
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 16'hA123)); // ISSUE s
        vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 16'hA123)); // ACK -> DONE
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 16'hA123)); // DONE -> FETCH
        vt.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 16'hA123)); // FETCH @2
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 16'hE000)); // LOAD halt word
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 16'hE000)); // HALT
        vt.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 16'hE000)); // HALT, start
        vt.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 16'hE000)); // FETCH @0
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'hD0A5)); // LOAD
        vt.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 16'hD0A5)); // ISSUE, start ignored
        vt.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 16'hD0A5)); // ISSUE, start ignored
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 16'hD0A5)); // ISSUE s

        #3;
        do_reset();
        #1;
        check("reset_state", {s, mem_rd, halted, pc, instr}, 64'd0);

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].st, vt[i].wv);
            ei = vt[i].e_instr;
            check($sformatf("vec%0d", i),
                  {mem_rd, s, halted, mem_addr, pc, instr, opcode, op},
                  {vt[i].e_rd, vt[i].e_s, vt[i].e_halt, vt[i].e_pc, vt[i].e_pc, ei, ei[15:13], ei[12:11]});
        end

        // reset while waiting in ACK
        step(1'b0, 1'b1);
        check("ack_no_reissue", s, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("rst_in_ack", {s, mem_rd, halted, pc, instr}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1);
            if (mem_rd || s) seen = 1'b1;
        end
        check("idle_after_rst", seen, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("restart_fetch", {mem_rd, mem_addr}, {1'b1, 8'd0});
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("issue_again", s, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_in_issue", {s, mem_rd, pc}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // pc wrap from 255 to 0
        for (int i = 0; i < 256; i++) mem[i] = {3'b001, 5'b00000, 8'(i)};
        do_reset();
        step(1'b1, 1'b1);
        wnext = 1'b1;
        phase = 0;
        for (int cyc = 0; cyc < 3000 && phase < 4; cyc++) begin
            step(1'b0, wnext);
            case (phase)
                0: if (mem_rd && mem_addr == 8'd255) phase = 1;
                1: begin check("wrap_load", {pc, instr}, {8'd255, mem[255]}); phase = 2; end
                2: begin check("wrap_pc", pc, 8'd0); phase = 3; end
                3: if (mem_rd) begin check("wrap_addr", mem_addr, 8'd0); phase = 4; end
                default: ;
            endcase
            wnext = s ? 1'b0 : 1'b1;
        end
        if (phase != 4) check("wrap_timeout", phase, 4);

        // randomized run against a transaction-level model
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        do_reset();
        exp_addr    = 8'd0;
        pend_valid  = 1'b0;
        pend_halt   = 1'b0;
        pend_issued = 1'b0;
        pend_addr   = 8'd0;
        pend_word   = 16'h0000;
        w_low       = 1'b1;
        halt_cnt    = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            st = ($urandom_range(0, 3) == 0);
            wv = ($urandom_range(0, 2) != 0);
            step(st, wv);
            if (halt_cnt > 0) begin
                halt_cnt--;
                if (halt_cnt == 0)
                    check("rnd_halt", {halted, pc}, {1'b1, pend_addr + 8'd1});
            end
            if (s) begin
                check("rnd_issue",
                      {w, mem_rd, pend_valid && !pend_halt && !pend_issued, instr, pc},
                      {1'b1, 1'b0, 1'b1, pend_word, pend_addr + 8'd1});
                pend_issued = 1'b1;
                w_low       = 1'b0;
            end
            if (mem_rd) begin
                check("rnd_fetch",
                      {mem_addr, !pend_valid || pend_halt || (pend_issued && w_low)},
                      {exp_addr, 1'b1});
                pend_valid  = 1'b1;
                pend_addr   = mem_addr;
                pend_word   = mem[mem_addr];
                pend_halt   = (pend_word[15:13] == 3'b111);
                pend_issued = 1'b0;
                exp_addr    = mem_addr + 8'd1;
                if (pend_halt) halt_cnt = 2;
            end
            if (pend_issued && !w) w_low = 1'b1;
            if (halted && st) begin
                exp_addr   = 8'd0;
                pend_valid = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_issue.md
INSTR_ISSUE -- requirements
Module: instr_issue

Interface
REQ-001 The block SHALL have one clock, with asynchronous active-low reset; ports are listed below.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin or restart execution from PC 0; sampled in IDLE or HALT only
- mem_rdata  in  16  instruction word; valid the cycle after mem_rd
- w  in  1  controller FSM waiting/idle flag (1 = ready for new instruction)
- mem_addr  out  8  instruction address (= pc)
- mem_rd  out  1  memory read strobe
- s  out  1  start pulse to controller FSM
- instr  out  16  instruction register contents
- opcode  out  3  instr[15:13]
- op  out  2  instr[12:11]
- pc  out  8  program counter
- halted  out  1  high while in HALT

Function
REQ-002 The FSM SHALL have states IDLE, FETCH, LOAD, ISSUE, ACK, DONE, HALT.
REQ-003 IDLE SHALL go to FETCH with pc=0 when start=1; otherwise it SHALL stay in IDLE.
REQ-004 FETCH SHALL assert mem_rd=1 for exactly one cycle with mem_addr=pc, then go to LOAD.
REQ-005 LOAD SHALL capture mem_rdata into instr and increment pc modulo 256 (255 wraps to 0).
REQ-006 From LOAD, opcode 3'b111 SHALL go to HALT; any other opcode SHALL go to ISSUE.
REQ-007 ISSUE SHALL hold s=0 while w=0; when w=1 it SHALL assert s=1 for exactly one cycle and go to ACK.
REQ-008 ACK SHALL wait for w=0 (controller accepted), then go to DONE.
REQ-009 DONE SHALL wait for w=1 (controller finished), then go to FETCH.
REQ-010 opcode and op SHALL be combinational slices of instr and SHALL stay stable from LOAD until the next LOAD.
REQ-011 HALT SHALL assert halted=1 and hold pc and instr; start=1 SHALL clear pc to 0 and go to FETCH.
REQ-012 start SHALL be ignored in every state except IDLE and HALT.
REQ-013 s and mem_rd SHALL never be high in the same cycle.
REQ-014 Latency SHALL be 3 cycles from start to the first s, when w=1 (FETCH, LOAD, ISSUE).
REQ-015 If w=1 already in ACK, the block SHALL stay in ACK; it SHALL not re-issue until w has gone 0 then 1.

Reset
REQ-016 When reset_n=0, the block SHALL asynchronously force state=IDLE, pc=0, instr=16'h0000, s=0, mem_rd=0 and halted=0.
REQ-017 Reset assertion in any state, including mid-handshake, SHALL abort the instruction without emitting further s pulses.
REQ-018 After reset_n deasserts, the block SHALL remain in IDLE until start=1.

Structure
REQ-019 A shared package SHALL hold the state encodings and the opcode constants OPC_MOV=3'b110, OPC_ALU=3'b101 and OPC_HALT=3'b111; the controller FSM SHALL use the same package.
REQ-020 The pc register with load-zero and increment controls SHALL be a sub-module named pc_counter; all remaining logic SHALL be in instr_issue.

Verification
REQ-021 Reset, then start=1 with mem[0]=16'hD0A5 and w=1: mem_rd SHALL pulse at cycle 1, instr=16'hD0A5 and opcode=110 SHALL appear at cycle 2, and s SHALL pulse once at cycle 3.
REQ-022 Hold w=1 for 4 cycles after s: there SHALL be no second s; then drop w for 2 cycles and raise it: the next fetch SHALL read mem_addr=1.
REQ-023 mem[2]=16'hE000 (halt): after 2 instructions halted SHALL be 1 with pc=3; start=1 SHALL then refetch address 0.
REQ-024 Preload pc to 255 with mem[255] non-halt: after LOAD, pc SHALL be 0 and the next mem_addr SHALL be 0.
REQ-025 Assert reset_n=0 in ACK: on that same edge s=0, state=IDLE and pc=0; with start held 0 afterwards, there SHALL be no further mem_rd.
REQ-026 Assert start in ISSUE with w=0: it SHALL be ignored, and s SHALL fire only once w=1.
